// File: rtl/audio_pkg.sv
// Shared sample-path types and constants for the speaker audio receive chain.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] MUTE_SAMPLE = 16'h0000;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO; head is visible on dout combinationally, push/pop take effect next edge.
// Push when full is ignored unless a pop frees a slot in the same cycle; pop when empty is ignored.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (ADDR_W+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= din;
  end

endmodule

// File: rtl/spi_sample_receiver.sv
// SPI mode-0 slave buffering 16-bit samples; each rising edge of done presents the next sample one clk later.
// No backpressure to the host: words arriving on a full FIFO are dropped and flagged; pops on empty mute.
module spi_sample_receiver
  import audio_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic              done,
  output logic [DATA_W-1:0] spkr_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PAD_W = DATA_W - ADDR_W - 3;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [2:0]        sck_s;
  logic [2:0]        cs_s;
  logic [1:0]        mosi_s;
  logic              sck_rise;
  logic              sck_fall;
  logic              cs_rise;
  logic              cs_fall;
  logic              mosi_bit;

  spi_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] status_word;
  logic              push_req;
  logic [DATA_W-1:0] push_dat;

  logic              done_q;
  logic              pop_req;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s  <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], sck};
      cs_s   <= {cs_s[1:0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign sck_rise    = sck_s[1] & ~sck_s[2];
  assign sck_fall    = ~sck_s[1] & sck_s[2];
  assign cs_rise     = cs_s[1] & ~cs_s[2];
  assign cs_fall     = ~cs_s[1] & cs_s[2];
  assign mosi_bit    = mosi_s[1];
  assign status_word = {overflow, underflow, {PAD_W{1'b0}}, fifo_level};
  assign miso        = tx_shift[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      push_req <= 1'b0;
      push_dat <= '0;
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            tx_shift <= status_word;
          end
        end
        SHIFT: begin
          // Deselect abandons any partial word without pushing it.
          if (cs_rise) begin
            state <= IDLE;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_bit};
            if (bit_cnt == LAST_BIT) begin
              push_req <= 1'b1;
              push_dat <= {rx_shift[DATA_W-2:0], mosi_bit};
              bit_cnt  <= '0;
              tx_shift <= status_word;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop_req = done & ~done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b0;
      spkr_data <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done_q <= done;
      if (pop_req) begin
        if (fifo_empty) begin
          spkr_data <= DATA_W'(MUTE_SAMPLE);
          underflow <= 1'b1;
        end else begin
          spkr_data <= fifo_head;
        end
      end
      // A full FIFO is never empty, so a same-cycle pop always makes room.
      if (push_req && fifo_full && !pop_req) overflow <= 1'b1;
    end
  end

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .din   (push_dat),
    .dout  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_spi_sample_receiver.sv
// Randomized bench for spi_sample_receiver against a queue-based sample model.
module tb_spi_sample_receiver;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_W     = 4;

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic              sck  = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              done = 1'b0;
  logic              miso;
  logic [DATA_W-1:0] spkr_data;
  logic [ADDR_W:0]   fifo_level;
  logic              overflow;
  logic              underflow;

  spi_sample_receiver #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .done       (done),
    .spkr_data  (spkr_data),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a queue of samples plus sticky flags and the presented sample.
  int          model_q[$];
  int          m_spkr = 0;
  int          m_ovf  = 0;
  int          m_udf  = 0;
  logic [15:0] tx_q[$];
  logic [15:0] miso_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int status_of_model();
    return m_ovf * 32768 + m_udf * 16384 + model_q.size();
  endfunction

  task automatic model_push(input int w);
    if (model_q.size() == FIFO_DEPTH) m_ovf = 1;
    else model_q.push_back(w);
  endtask

  task automatic model_pop();
    if (model_q.size() == 0) begin
      m_spkr = 0;
      m_udf  = 1;
    end else begin
      m_spkr = model_q.pop_front();
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_spkr = 0;
    m_ovf  = 0;
    m_udf  = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_level"}, 32'(fifo_level), 32'(model_q.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_udf"}, 32'(underflow), 32'(m_udf));
    chk({tag, "_spkr"}, 32'(spkr_data), 32'(m_spkr));
  endtask

  // Ten clk per SCK bit; with pop_last the done strobe lands on the push cycle of the final bit.
  task automatic send_bits(input logic [15:0] w, input int nbits, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[DATA_W-1-i];
      tick(5);
      miso_word[DATA_W-1-i] = miso;
      sck = 1'b1;
      if (pop_last && i == nbits - 1) begin
        tick(3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(1);
      end else begin
        tick(5);
      end
      sck = 1'b0;
    end
  endtask

  task automatic frame(input bit pop_last);
    int exp_status;
    int n;
    exp_status = status_of_model();
    n = tx_q.size();
    cs_n = 1'b0;
    tick(5);
    for (int k = 0; k < n; k++) begin
      send_bits(tx_q[k], 16, pop_last && (k == n - 1));
      if (k == 0) chk("miso_status", 32'(miso_word), 32'(exp_status));
      if (pop_last && (k == n - 1)) model_pop();
      model_push(int'(tx_q[k]));
    end
    tick(5);
    cs_n = 1'b1;
    tick(5);
    tx_q.delete();
  endtask

  task automatic done_pulse(input string tag);
    done = 1'b1;
    tick(1);
    model_pop();
    chk({tag, "_spkr"}, 32'(spkr_data), 32'(m_spkr));
    chk({tag, "_level"}, 32'(fifo_level), 32'(model_q.size()));
    done = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(3);
    check_all("reset");
    chk("reset_miso", 32'(miso), 32'd0);
    rst = 1'b0;
    tick(5);

    tx_q.push_back(16'hA55A);
    frame(1'b0);
    check_all("a55a_rx");
    done_pulse("a55a_pop");

    tx_q.push_back(16'h0001);
    tx_q.push_back(16'h0002);
    tx_q.push_back(16'h0003);
    frame(1'b0);
    check_all("seq_rx");
    for (int i = 0; i < 4; i++) done_pulse("seq_pop");
    check_all("underflow");

    tx_q.push_back(16'($urandom));
    tx_q.push_back(16'($urandom));
    frame(1'b0);
    done = 1'b1;
    tick(20);
    done = 1'b0;
    model_pop();
    tick(2);
    check_all("done_held");
    done_pulse("done_held_drain");

    cs_n = 1'b0;
    tick(5);
    send_bits(16'hFFFF, 9, 1'b0);
    tick(5);
    cs_n = 1'b1;
    tick(5);
    check_all("partial");
    tx_q.push_back(16'h1234);
    frame(1'b0);
    check_all("after_partial");
    done_pulse("pop_1234");

    for (int i = 0; i < FIFO_DEPTH; i++) tx_q.push_back(16'($urandom));
    frame(1'b0);
    check_all("fill");
    tx_q.push_back(16'($urandom));
    frame(1'b1);
    check_all("push_pop_full");
    for (int i = 0; i < FIFO_DEPTH; i++) done_pulse("drain_a");

    for (int i = 0; i < FIFO_DEPTH + 1; i++) tx_q.push_back(16'($urandom));
    frame(1'b0);
    check_all("overflow");
    for (int i = 0; i < FIFO_DEPTH; i++) done_pulse("drain_b");

    for (int i = 0; i < 3; i++) tx_q.push_back(16'($urandom));
    frame(1'b0);
    check_all("pre_rst");
    cs_n = 1'b0;
    tick(5);
    send_bits(16'h5AA5, 8, 1'b0);
    rst = 1'b1;
    tick(1);
    model_reset();
    check_all("mid_rst");
    chk("mid_rst_miso", 32'(miso), 32'd0);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    tx_q.push_back(16'hBEEF);
    frame(1'b0);
    check_all("beef_rx");
    tx_q.push_back(16'($urandom));
    frame(1'b0);
    done_pulse("beef_pop");

    for (int it = 0; it < 6; it++) begin
      int nw;
      int np;
      nw = $urandom_range(1, 5);
      np = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) tx_q.push_back(16'($urandom));
      frame(1'b0);
      check_all("rand_rx");
      for (int i = 0; i < np; i++) done_pulse("rand_pop");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
